// File: rtl/tjrpu_pkg.sv
// Shared types and constants for the tjrpu memory subsystem.
// Optional build macro used by tjrpu_mem_arbiter: TJRPU_MEM_WBERR_EN.
package tjrpu_pkg;

    // Arbiter sequencing states: one SRAM access takes exactly three cycles.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Identity of the requester that owns (or last owned) the SRAM.
    typedef enum logic {
        GNT_WB   = 1'b0,
        GNT_CORE = 1'b1
    } arb_src_t;

    // Bit positions of each requester in the two-bit request/grant vectors.
    localparam int LANE_WB   = 0;
    localparam int LANE_CORE = 1;

    // Wishbone byte address of SRAM word 0.
    localparam logic [31:0] MEM_BASE_ADDR = 32'h3000_0000;

endpackage

// File: rtl/tjrpu_rr_arb2.sv
// Two-requester round-robin arbiter, purely combinational.
// A lone requester always wins; on a tie the requester that did not win
// last time is granted. Grant is one-hot or zero.
module tjrpu_rr_arb2
    import tjrpu_pkg::*;
(
    input  logic [1:0] req,
    input  arb_src_t   last_grant,
    output logic [1:0] gnt
);

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam arb_src_t LANE_SRC = (gi == LANE_WB) ? GNT_WB : GNT_CORE;
        // A lane wins when it asks and either the other lane is quiet or it is this lane's turn.
        assign gnt[gi] = req[gi] & (~req[1 - gi] | (last_grant != LANE_SRC));
    end

endmodule

// File: rtl/tjrpu_mem_arbiter.sv
// Shares the single-port data SRAM between the Caravel Wishbone slave port and
// the tile core memory port. Each access runs IDLE -> ACCESS -> RESP with no
// overlap; arbitration is a fair 2-way round robin.
// Optional build macro: TJRPU_MEM_WBERR_EN -- when defined, out-of-window
// Wishbone accesses terminate with wbs_err_o instead of a zero-data ack.
module tjrpu_mem_arbiter
    import tjrpu_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = MEM_BASE_ADDR
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [DATA_W/8-1:0]   wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [DATA_W-1:0]     wbs_dat_i,
    output logic                  wbs_ack_o,
`ifdef TJRPU_MEM_WBERR_EN
    output logic                  wbs_err_o,
`endif
    output logic [DATA_W-1:0]     wbs_dat_o,
    input  logic                  core_req_i,
    input  logic                  core_we_i,
    input  logic [DATA_W/8-1:0]   core_sel_i,
    input  logic [ADDR_W-1:0]     core_adr_i,
    input  logic [DATA_W-1:0]     core_wdata_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    output logic [DATA_W-1:0]     core_rdata_o,
    output logic                  mem_en_o,
    output logic [DATA_W/8-1:0]   mem_we_o,
    output logic [ADDR_W-1:0]     mem_adr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam int          SEL_W        = DATA_W / 8;
    localparam logic [31:0] WINDOW_BYTES = 32'd4 << ADDR_W;

    arb_state_t          state_reg;
    arb_src_t            last_grant_reg;
    arb_src_t            src_reg;
    logic                we_reg;
    logic [SEL_W-1:0]    sel_reg;
    logic [ADDR_W-1:0]   adr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                oow_reg;
    logic                abort_reg;

    logic [31:0]         wb_off;
    logic                in_window;
    logic                wb_bid_any;
    logic                wb_req;
    logic                wb_oow;
    logic                core_bid;
    logic [1:0]          arb_req;
    logic [1:0]          arb_gnt;
    logic                resp_live;
    logic                wb_resp;
    logic                core_rd_resp;

    // Offset into the SRAM window; the unsigned compare also rejects addresses below the base.
    assign wb_off    = wbs_adr_i - BASE_ADDR;
    assign in_window = wb_off < WINDOW_BYTES;

    // Requests are only considered in IDLE and never while reset is asserted.
    assign wb_bid_any = wbs_cyc_i & wbs_stb_i & (state_reg == IDLE) & ~wb_rst_i;
    assign wb_req     = wb_bid_any & in_window;
    assign wb_oow     = wb_bid_any & ~in_window;
    assign core_bid   = core_req_i & (state_reg == IDLE) & ~wb_rst_i;

    // Out-of-window Wishbone cycles still take a turn in the round robin so a
    // misbehaving master cannot starve the core or jump the queue.
    assign arb_req[LANE_WB]   = wb_req | wb_oow;
    assign arb_req[LANE_CORE] = core_bid;

    tjrpu_rr_arb2 u_rr_arb2 (
        .req        (arb_req),
        .last_grant (last_grant_reg),
        .gnt        (arb_gnt)
    );

    // The core sees its grant in the same cycle the decision is made.
    assign core_gnt_o = arb_gnt[LANE_CORE];

    // Sequencer: latch the winner's request in IDLE, then walk ACCESS and RESP.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg      <= IDLE;
            last_grant_reg <= GNT_CORE;
            src_reg        <= GNT_WB;
            we_reg         <= 1'b0;
            sel_reg        <= '0;
            adr_reg        <= '0;
            wdata_reg      <= '0;
            oow_reg        <= 1'b0;
            abort_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    abort_reg <= 1'b0;
                    if (arb_gnt[LANE_WB]) begin
                        src_reg        <= GNT_WB;
                        last_grant_reg <= GNT_WB;
                        we_reg         <= wbs_we_i;
                        sel_reg        <= wbs_sel_i;
                        adr_reg        <= wb_off[ADDR_W+1:2];
                        wdata_reg      <= wbs_dat_i;
                        oow_reg        <= ~in_window;
                        // Out-of-window cycles skip the SRAM entirely.
                        state_reg      <= in_window ? ACCESS : RESP;
                    end else if (arb_gnt[LANE_CORE]) begin
                        src_reg        <= GNT_CORE;
                        last_grant_reg <= GNT_CORE;
                        we_reg         <= core_we_i;
                        sel_reg        <= core_sel_i;
                        adr_reg        <= core_adr_i;
                        wdata_reg      <= core_wdata_i;
                        oow_reg        <= 1'b0;
                        state_reg      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A master dropping cyc here abandons the cycle; the SRAM op still happens.
                    if (src_reg == GNT_WB && !wbs_cyc_i) begin
                        abort_reg <= 1'b1;
                    end
                    state_reg <= RESP;
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // SRAM port: driven only in ACCESS; reset in that cycle squashes the operation.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = '0;
        mem_adr_o   = '0;
        mem_wdata_o = '0;
        if (state_reg == ACCESS && !wb_rst_i) begin
            mem_en_o    = 1'b1;
            mem_we_o    = we_reg ? sel_reg : '0;
            mem_adr_o   = adr_reg;
            mem_wdata_o = wdata_reg;
        end
    end

    assign resp_live    = (state_reg == RESP) & ~wb_rst_i;
    assign wb_resp      = resp_live & (src_reg == GNT_WB) & ~abort_reg & wbs_cyc_i;
    assign core_rd_resp = resp_live & (src_reg == GNT_CORE) & ~we_reg;

    // Response pulses in RESP; SRAM read data passes straight through with the pulse.
    always_comb begin
`ifdef TJRPU_MEM_WBERR_EN
        wbs_ack_o = wb_resp & ~oow_reg;
        wbs_err_o = wb_resp & oow_reg;
`else
        wbs_ack_o = wb_resp;
`endif
        wbs_dat_o     = (wb_resp && !oow_reg && !we_reg) ? mem_rdata_i : '0;
        core_rvalid_o = core_rd_resp;
        core_rdata_o  = core_rd_resp ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_tjrpu_mem_arbiter.sv
// Scoreboard bench for tjrpu_mem_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares on every ack / rvalid / err pulse.
// Build macro TJRPU_MEM_WBERR_EN selects the error-response variant.
module tb_tjrpu_mem_arbiter;

    localparam int K_ACK    = 0;
    localparam int K_RVALID = 1;
    localparam int K_ERR    = 2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o, wbs_err_o;
    logic [31:0] wbs_dat_o;
    logic        core_req_i = 1'b0, core_we_i = 1'b0;
    logic [3:0]  core_sel_i = '0;
    logic [9:0]  core_adr_i = '0;
    logic [31:0] core_wdata_i = '0;
    logic        core_gnt_o, core_rvalid_o;
    logic [31:0] core_rdata_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [9:0]  mem_adr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int    tests_run = 0;
    int    tests_failed = 0;
    resp_t exp_q[$];
    logic  ack_prev = 1'b0;

    always #5 clk = ~clk;

    tjrpu_mem_arbiter dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (wb_rst_i),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_ack_o     (wbs_ack_o),
`ifdef TJRPU_MEM_WBERR_EN
        .wbs_err_o     (wbs_err_o),
`endif
        .wbs_dat_o     (wbs_dat_o),
        .core_req_i    (core_req_i),
        .core_we_i     (core_we_i),
        .core_sel_i    (core_sel_i),
        .core_adr_i    (core_adr_i),
        .core_wdata_i  (core_wdata_i),
        .core_gnt_o    (core_gnt_o),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .mem_en_o      (mem_en_o),
        .mem_we_o      (mem_we_o),
        .mem_adr_o     (mem_adr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i)
    );

`ifndef TJRPU_MEM_WBERR_EN
    assign wbs_err_o = 1'b0;
`endif

    // Behavioural 1024x32 SRAM with byte writes and one-cycle read latency.
    logic [31:0] sram [0:1023];
    always @(posedge clk) begin
        if (mem_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we_o[b]) sram[mem_adr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
            mem_rdata_i <= sram[mem_adr_o];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic expect_resp(input int kind, input logic [31:0] data);
        resp_t r;
        r.kind = kind[1:0];
        r.data = data;
        exp_q.push_back(r);
    endtask

    // Monitor: every response pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        resp_t e;
        logic [1:0] k;
        logic [31:0] d;
        if (wbs_ack_o || core_rvalid_o || wbs_err_o) begin
            k = wbs_ack_o ? 2'(K_ACK) : (core_rvalid_o ? 2'(K_RVALID) : 2'(K_ERR));
            d = core_rvalid_o ? core_rdata_o : wbs_dat_o;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected response: got kind %0d data 0x%08h, expected none", k, d);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard response", {30'd0, k, d}, {30'd0, e.kind, e.data});
            end
        end
        if (wbs_ack_o && ack_prev) begin
            tests_run++;
            tests_failed++;
            $display("FAIL ack back-to-back: got 2 consecutive acks, expected at most 1");
        end
        ack_prev = wbs_ack_o;
    end

    // Wishbone master: entered and left just after a rising edge.
    task automatic wb_xfer(input string name, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input int exp_lat, input logic exp_mem);
        int n = 0;
        int en_cnt = 0;
        bit done = 0;
        logic [31:0] word = (adr - 32'h3000_0000) >> 2;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = 4'hF; wbs_adr_i = adr; wbs_dat_i = dat;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_en_o) en_cnt++;
            if (exp_mem && n == exp_lat - 1) begin
                check({name, " mem_en"}, 64'(mem_en_o), 64'd1);
                check({name, " mem_adr"}, 64'(mem_adr_o), 64'(word[9:0]));
                check({name, " mem_we"}, 64'(mem_we_o), we ? 64'hF : 64'h0);
            end
            if (wbs_ack_o || wbs_err_o) done = 1;
        end
        check({name, " latency"}, 64'(n), 64'(exp_lat));
        if (!exp_mem) check({name, " no sram"}, 64'(en_cnt), 64'd0);
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    // Core master: holds req until grant, then withdraws just after the next edge.
    task automatic core_xfer(input string name, input logic we, input logic [9:0] adr,
                             input logic [3:0] sel, input logic [31:0] dat, input int exp_wait);
        int n = 0;
        bit done = 0;
        core_req_i = 1'b1; core_we_i = we; core_sel_i = sel;
        core_adr_i = adr; core_wdata_i = dat;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (core_gnt_o) done = 1;
        end
        check({name, " gnt wait"}, 64'(n), 64'(exp_wait));
        @(posedge clk); #1;
        core_req_i = 1'b0; core_we_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, " ctrl"}, {59'd0, wbs_ack_o, core_gnt_o, core_rvalid_o, mem_en_o, wbs_err_o}, 64'd0);
        check({name, " mem_we/adr"}, {50'd0, mem_we_o, mem_adr_o}, 64'd0);
        check({name, " mem_wdata"}, 64'(mem_wdata_o), 64'd0);
        check({name, " rd buses"}, {wbs_dat_o, core_rdata_o}, 64'd0);
    endtask

    initial begin
        // Reset state.
        idle_cycles(2);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        wb_rst_i = 1'b0;

        // 1: WB writes then read-back; ack in the third cycle.
        expect_resp(K_ACK, 32'h0);
        wb_xfer("t1 wr 0x10", 1'b1, 32'h3000_0010, 32'hCAFE_BABE, 3, 1'b1);
        expect_resp(K_ACK, 32'h0);
        wb_xfer("t1 wr 0x14", 1'b1, 32'h3000_0014, 32'h1234_5678, 3, 1'b1);
        expect_resp(K_ACK, 32'hCAFE_BABE);
        wb_xfer("t1 rd 0x10", 1'b0, 32'h3000_0010, 32'h0, 3, 1'b1);

        // 2: simultaneous requests after reset; WB first, then strict alternation.
        wb_rst_i = 1'b1;
        idle_cycles(1);
        wb_rst_i = 1'b0;
        expect_resp(K_ACK, 32'hCAFE_BABE);
        expect_resp(K_RVALID, 32'hCAFE_BABE);
        expect_resp(K_ACK, 32'h1234_5678);
        expect_resp(K_RVALID, 32'h1234_5678);
        fork
            begin
                wb_xfer("t2 wb rd1", 1'b0, 32'h3000_0010, 32'h0, 3, 1'b1);
                wb_xfer("t2 wb rd2", 1'b0, 32'h3000_0014, 32'h0, 6, 1'b1);
            end
            begin
                core_xfer("t2 core rd1", 1'b0, 10'd4, 4'hF, 32'h0, 4);
                core_xfer("t2 core rd2", 1'b0, 10'd5, 4'hF, 32'h0, 6);
            end
        join
        idle_cycles(4);

        // 3: core byte-lane write merge.
        core_xfer("t3 core wr full", 1'b1, 10'd8, 4'hF, 32'hFFFF_FFFF, 1);
        core_xfer("t3 core wr lane1", 1'b1, 10'd8, 4'b0010, 32'h1122_3344, 3);
        @(negedge clk);
        check("t3 access mem_we", 64'(mem_we_o), 64'h2);
        check("t3 access wdata", 64'(mem_wdata_o), 64'h1122_3344);
        @(posedge clk); #1;
        expect_resp(K_RVALID, 32'hFFFF_33FF);
        core_xfer("t3 core rd", 1'b0, 10'd8, 4'hF, 32'h0, 2);
        idle_cycles(3);

        // 4: WB abort during ACCESS of a write: write lands, no ack.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0040; wbs_dat_i = 32'h5;
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(negedge clk);
        check("t4 abort write en/we", {59'd0, mem_en_o, mem_we_o}, 64'h1F);
        @(negedge clk);
        check("t4 abort no ack", 64'(wbs_ack_o), 64'd0);
        @(posedge clk); #1;
        expect_resp(K_ACK, 32'h5);
        wb_xfer("t4 rd after abort", 1'b0, 32'h3000_0040, 32'h0, 3, 1'b1);

        // 5: reset pulsed in ACCESS of a core read.
        core_xfer("t5 core rd", 1'b0, 10'd4, 4'hF, 32'h0, 1);
        wb_rst_i = 1'b1;
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        @(negedge clk);
        check_all_zero("t5 after reset");
        @(posedge clk); #1;
        expect_resp(K_RVALID, 32'hCAFE_BABE);
        core_xfer("t5 core rd idle", 1'b0, 10'd4, 4'hF, 32'h0, 1);
        idle_cycles(3);

        // 6: out-of-window accesses and the window boundary.
`ifdef TJRPU_MEM_WBERR_EN
        expect_resp(K_ERR, 32'h0);
        wb_xfer("t6 oow rd", 1'b0, 32'h2000_0000, 32'h0, 2, 1'b0);
        expect_resp(K_ERR, 32'h0);
        wb_xfer("t6 oow wr", 1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 2, 1'b0);
        expect_resp(K_ERR, 32'h0);
        wb_xfer("t6 above top", 1'b0, 32'h3000_1000, 32'h0, 2, 1'b0);
`else
        expect_resp(K_ACK, 32'h0);
        wb_xfer("t6 oow rd", 1'b0, 32'h2000_0000, 32'h0, 2, 1'b0);
        expect_resp(K_ACK, 32'h0);
        wb_xfer("t6 oow wr", 1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 2, 1'b0);
        expect_resp(K_ACK, 32'h0);
        wb_xfer("t6 above top", 1'b0, 32'h3000_1000, 32'h0, 2, 1'b0);
`endif
        expect_resp(K_ACK, 32'hCAFE_BABE);
        wb_xfer("t6 word4 intact", 1'b0, 32'h3000_0010, 32'h0, 3, 1'b1);
        expect_resp(K_ACK, 32'h0);
        wb_xfer("t6 wr top word", 1'b1, 32'h3000_0FFC, 32'h600D_F00D, 3, 1'b1);
        expect_resp(K_ACK, 32'h600D_F00D);
        wb_xfer("t6 rd top word", 1'b0, 32'h3000_0FFC, 32'h0, 3, 1'b1);

        idle_cycles(4);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop if something wedges the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

endmodule
